// File: rtl/dual_issue_queue.sv
// Instruction queue between fetch and the paired decoder; presents the two oldest entries as an issue pair.
// Optional statistics counters are enabled by defining DUAL_ISSUE_QUEUE_STATS_EN.
module dual_issue_queue #(
  parameter int els_p        = 4,
  parameter int data_width_p = 32,
  parameter int pc_width_p   = 22
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         fetch_v_i,
  input  logic [data_width_p-1:0]      fetch_instr_i,
  input  logic [pc_width_p-1:0]        fetch_pc_i,
  output logic                         fetch_ready_o,
  output logic                         instr0_v_o,
  output logic [data_width_p-1:0]      instr0_o,
  output logic [pc_width_p-1:0]        pc0_o,
  output logic                         instr1_v_o,
  output logic [data_width_p-1:0]      instr1_o,
  output logic [pc_width_p-1:0]        pc1_o,
  input  logic                         dual_issue_i,
  input  logic                         issue_i,
  input  logic                         flush_i,
  output logic [$clog2(els_p+1)-1:0]   count_o
`ifdef DUAL_ISSUE_QUEUE_STATS_EN
  ,
  output logic [31:0]                  single_issue_cnt_o,
  output logic [31:0]                  dual_issue_cnt_o,
  output logic [31:0]                  starve_cnt_o
`endif
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p+1);

  typedef enum logic {eRUN, eFLUSH} state_e;

  state_e                  r_state, w_state_next;
  logic [ptr_w-1:0]        r_rd_ptr, r_wr_ptr, w_rd1_ptr;
  logic [cnt_w-1:0]        r_count;
  logic [data_width_p-1:0] r_mem_instr [els_p];
  logic [pc_width_p-1:0]   r_mem_pc    [els_p];

  logic       w_push, w_issue, w_pop1, w_pop2;
  logic [1:0] w_pop_n;

  assign instr0_v_o    = (r_count >= cnt_w'(1));
  assign instr1_v_o    = (r_count >= cnt_w'(2));
  assign fetch_ready_o = (r_state == eRUN) && (r_count < cnt_w'(els_p));
  assign count_o       = r_count;
  assign w_rd1_ptr     = r_rd_ptr + ptr_w'(1);

  // Flush wins over push/pop in the same cycle.
  assign w_push  = fetch_v_i & fetch_ready_o & ~flush_i;
  assign w_issue = issue_i & instr0_v_o & ~flush_i;
  assign w_pop2  = w_issue & dual_issue_i & instr1_v_o;
  assign w_pop1  = w_issue & ~w_pop2;
  assign w_pop_n = {w_pop2, w_pop1};

  always_comb begin
    w_state_next = r_state;
    if (flush_i)                w_state_next = eFLUSH;
    else if (r_state == eFLUSH) w_state_next = eRUN;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state  <= eRUN;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_next;
      if (flush_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + ptr_w'(1);
        r_rd_ptr <= r_rd_ptr + ptr_w'(w_pop_n);
        r_count  <= r_count + cnt_w'(w_push) - cnt_w'(w_pop_n);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= fetch_instr_i;
      r_mem_pc[r_wr_ptr]    <= fetch_pc_i;
    end
  end

  always_comb begin
    instr0_o = '0;
    pc0_o    = '0;
    instr1_o = '0;
    pc1_o    = '0;
    if (instr0_v_o) begin
      instr0_o = r_mem_instr[r_rd_ptr];
      pc0_o    = r_mem_pc[r_rd_ptr];
    end
    if (instr1_v_o) begin
      instr1_o = r_mem_instr[w_rd1_ptr];
      pc1_o    = r_mem_pc[w_rd1_ptr];
    end
  end

`ifdef DUAL_ISSUE_QUEUE_STATS_EN
  logic [31:0] r_single_cnt, r_dual_cnt, r_starve_cnt;

  // Saturating counters; flush leaves them untouched.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_single_cnt <= '0;
      r_dual_cnt   <= '0;
      r_starve_cnt <= '0;
    end else begin
      if (w_pop1 && (r_single_cnt != '1)) r_single_cnt <= r_single_cnt + 32'd1;
      if (w_pop2 && (r_dual_cnt != '1))   r_dual_cnt   <= r_dual_cnt + 32'd1;
      if (issue_i && (r_count == '0) && (r_starve_cnt != '1))
        r_starve_cnt <= r_starve_cnt + 32'd1;
    end
  end

  assign single_issue_cnt_o = r_single_cnt;
  assign dual_issue_cnt_o   = r_dual_cnt;
  assign starve_cnt_o       = r_starve_cnt;
`endif

endmodule
